activation_pipe: RTL and testbench
==================================

Name: activation_pipe

Overview:
- Multi-channel, pipelined, mode-selectable activation unit for the neuron datapath. It replaces the single-lane combinational sigmoid.
- Takes NCH fixed-point pre-activation sums from the MAC stage. Applies sigmoid, tanh, ReLU or saturating identity per transaction through a 2-stage registered pipeline.
- Uses valid/ready handshakes on input and output, so the downstream layer buffer can stall it.

Parameters:
- N, 2, extra integer guard bits of the input sum
- QM, 6, integer bits of the input format
- QN, 10, fractional bits of the input format
- NCH, 4, number of parallel channels (lanes), >= 1
- LUT_BITS, 8, LUT index width; table covers ±2^(LUT_BITS-1) steps
- LUT_QN, 5, fractional bits of LUT index and output, < QN
- OUT_W, 8, output width per lane (signed)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  unit can accept input this cycle
- in_mode  in  2  0 = sigmoid, 1 = tanh, 2 = ReLU, 3 = identity
- in_data  in  NCH*(QM+QN+N)  lane k at bits [k*IW +: IW], IW = QM+QN+N, signed
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts output
- out_mode  out  2  mode that produced out_data
- out_data  out  NCH*OUT_W  lane k at bits [k*OUT_W +: OUT_W], signed, LUT_QN fractional bits

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state is cleared on the clk edge where rst=1.
- Reset values: s1_valid=0, out_valid=0, out_data=0, out_mode=0. in_ready=0 while rst=1.
- Transfers:
  - Input transfer on an edge with in_valid && in_ready.
  - Output transfer on an edge with out_valid && out_ready.
- Stage 1 (quantise), per lane:
  - xq = floor(x * 2^LUT_QN): arithmetic right shift of in by (QN-LUT_QN), truncation toward -inf.
  - Clamp xq to [-H, +H], H = 2^(LUT_BITS-1).
  - Register clamped xq and mode. Identity/ReLU also register the unclamped xq saturated to OUT_W signed.
- Stage 2 (evaluate), per lane, registered into out_data:
  - sigmoid: round(2^LUT_QN / (1 + e^(-xq/2^LUT_QN)))
  - tanh: round(2^LUT_QN * tanh(xq/2^LUT_QN)), signed
  - ReLU: max(0, xq) saturated to 2^(OUT_W-1)-1
  - identity: xq saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
  - The sigmoid and tanh tables are constants elaborated from parameters: 2H+1 entries each, rounding to nearest, ties away from zero. They are shared across lanes by replication, not time-multiplexed.
- Latency: exactly 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 transaction per cycle.
- Flow control:
  - s2_adv = !out_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv && !rst
  - Stage 2 loads s1 contents and s1_valid on s2_adv.
  - Stage 1 loads input and in_valid on s1_adv.
- Stall: while out_valid && !out_ready, out_data and out_mode stay stable. Stage 1 holds its contents. in_ready drops once s1_valid=1. No transaction is dropped or duplicated.
- Simultaneous output transfer and new s1 data: stage 2 loads the new data in the same edge, so the pipe runs bubble-free.
- Mode travels with its transaction. Mode changes between back-to-back transactions take effect per transaction, with no flush.
- Reset mid-operation: all in-flight transactions are discarded. out_valid=0 on the next cycle.
- Out-of-range inputs saturate as above and never wrap. The xq clamp precedes the table lookup.

Test Plan (defaults: IW=18, LUT_QN=5, 1.0 = 1024 on input):
- Reset then in_data all lanes 0, mode 0, out_ready=1 -> 2 cycles later out_valid=1, every lane out=16. Mode 1 on the same input -> 0.
- Lanes {1024, -1024, 10240, -10240}, mode 0 -> {23, 9, 31, 1}. Mode 1 -> {24, -24, 32, -32}.
- Lanes {-1024, 2560, 10240, 0}, mode 2 -> {0, 80, 127, 0}. Mode 3 with {10240, -10240, 32, 31} -> {127, -128, 1, 0}: 31>>5 floors to 0, and 32 -> xq=1.
- Stream 8 back-to-back transactions with mixed modes and out_ready=1 -> 8 consecutive out_valid cycles, correct per-transaction mode/data, in_ready constantly 1.
- Hold out_ready=0 for 5 cycles mid-stream -> out_data stable, in_ready=0 after one more accepted input. Release -> remaining outputs arrive in order with no loss or duplicates.
- Assert rst for 1 cycle with 2 transactions in flight -> out_valid=0 and out_data=0 the next cycle, no stale output emitted afterwards.

Source files
------------

// File: rtl/activation_pipe.sv
// activation_pipe: NCH-lane, 2-stage valid/ready activation unit (sigmoid, tanh, ReLU, identity)
module activation_pipe #(
    parameter int N        = 2,
    parameter int QM       = 6,
    parameter int QN       = 10,
    parameter int NCH      = 4,
    parameter int LUT_BITS = 8,
    parameter int LUT_QN   = 5,
    parameter int OUT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_mode,
    input  logic [NCH*(QM+QN+N)-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_mode,
    output logic [NCH*OUT_W-1:0]    out_data
);
    localparam int IW = QM + QN + N;
    localparam int SH = QN - LUT_QN;
    localparam int H  = 1 << (LUT_BITS - 1);
    localparam logic signed [IW-1:0] HP = IW'(H);
    localparam logic signed [IW-1:0] HN = IW'(-H);
    localparam logic signed [IW-1:0] OP = IW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IW-1:0] ON = IW'(-(1 << (OUT_W - 1)));
    localparam logic [LUT_BITS:0] IB = (LUT_BITS + 1)'(H);

    // Elaboration-time table value, rounded to nearest with ties away from zero
    function automatic int act_val(input int x, input bit t);
        real s, r, v;
        s = real'(1 << LUT_QN);
        r = real'(x) / s;
        v = t ? s * $tanh(r) : s / (1.0 + $exp(-r));
        return v < 0.0 ? -$rtoi(0.5 - v) : $rtoi(v + 0.5);
    endfunction

    logic signed [OUT_W-1:0] sig_lut [2*H+1];
    logic signed [OUT_W-1:0] tanh_lut [2*H+1];
    logic                    s1_valid;
    logic [1:0]              s1_mode;
    logic [LUT_BITS:0]       s1_idx [NCH];
    logic signed [OUT_W-1:0] s1_sat [NCH];
    logic [LUT_BITS:0]       idx [NCH];
    logic signed [OUT_W-1:0] sat [NCH];
    logic signed [OUT_W-1:0] res [NCH];
    logic                    s1_adv, s2_adv;

    genvar i, k;
    for (i = 0; i < 2*H+1; i++) begin : g_lut
        assign sig_lut[i]  = OUT_W'(act_val(i - H, 1'b0));
        assign tanh_lut[i] = OUT_W'(act_val(i - H, 1'b1));
    end

    for (k = 0; k < NCH; k++) begin : g_lane
        logic signed [IW-1:0] x, xq;
        assign x  = in_data[k*IW +: IW];
        assign xq = x >>> SH;
        // Clamped value is stored as a table index offset by H
        assign idx[k] = (LUT_BITS + 1)'(xq > HP ? HP : xq < HN ? HN : xq) + IB;
        assign sat[k] = OUT_W'(xq > OP ? OP : xq < ON ? ON : xq);
        assign res[k] = s1_mode == 2'd0 ? sig_lut[s1_idx[k]] :
                        s1_mode == 2'd1 ? tanh_lut[s1_idx[k]] :
                        (s1_mode == 2'd2 && s1_sat[k][OUT_W-1]) ? '0 : s1_sat[k];
    end

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_mode   <= '0;
            out_valid <= 1'b0;
            out_mode  <= '0;
            out_data  <= '0;
            for (int j = 0; j < NCH; j++) begin
                s1_idx[j] <= '0;
                s1_sat[j] <= '0;
            end
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                s1_mode  <= in_mode;
                for (int j = 0; j < NCH; j++) begin
                    s1_idx[j] <= idx[j];
                    s1_sat[j] <= sat[j];
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                out_mode  <= s1_mode;
                for (int j = 0; j < NCH; j++)
                    out_data[j*OUT_W +: OUT_W] <= res[j];
            end
        end
    end
endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: randomized scoreboard bench with a real-arithmetic reference model
module tb_activation_pipe;
    localparam int NCH = 4, IW = 18, OW = 8;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]        in_mode, out_mode;
    logic [NCH*IW-1:0] in_data;
    logic [NCH*OW-1:0] out_data;

    typedef struct packed {
        logic [1:0]        m;
        logic [NCH*OW-1:0] d;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    activation_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real v);
        return v < 0.0 ? -$rtoi(0.5 - v) : $rtoi(v + 0.5);
    endfunction

    function automatic logic [NCH*OW-1:0] model(input logic [1:0] m, input logic [NCH*IW-1:0] d);
        logic [NCH*OW-1:0] r;
        int x, xq, c, v;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            x  = int'($signed(d[k*IW +: IW]));
            xq = (x - (((x % 32) + 32) % 32)) / 32;
            c  = xq > 128 ? 128 : (xq < -128 ? -128 : xq);
            case (m)
                2'd0:    v = rnd(32.0 / (1.0 + $exp(-real'(c) / 32.0)));
                2'd1:    v = rnd(32.0 * $tanh(real'(c) / 32.0));
                2'd2:    v = xq < 0 ? 0 : (xq > 127 ? 127 : xq);
                default: v = xq < -128 ? -128 : (xq > 127 ? 127 : xq);
            endcase
            r[k*OW +: OW] = 8'(v);
        end
        return r;
    endfunction

    function automatic logic [17:0] rl();
        int b [8];
        b = '{4096, -4096, 4095, -4097, 131071, -131072, 31, -32};
        case ($urandom_range(0, 3))
            0:       return 18'($urandom_range(0, 8191) - 4096);
            1:       return 18'($urandom);
            2:       return 18'(b[$urandom_range(0, 7)]);
            default: return 18'($urandom_range(0, 255) - 128);
        endcase
    endfunction

    function automatic logic [NCH*IW-1:0] lin(input int a, input int b, input int c, input int d);
        return {18'(d), 18'(c), 18'(b), 18'(a)};
    endfunction

    function automatic logic [NCH*OW-1:0] lout(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    // Present one transaction and wait (bounded) until it is accepted
    task automatic send(input logic [1:0] m, input logic [NCH*IW-1:0] d, input logic [NCH*OW-1:0] e);
        bit done = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        #1;
        for (int t = 0; t < 50 && !done; t++) begin
            if (in_ready) begin
                q.push_back('{m, e});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 want accept within 50 cycles");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rand();
        logic [1:0]        m;
        logic [NCH*IW-1:0] d;
        m = 2'($urandom_range(0, 3));
        d = {rl(), rl(), rl(), rl()};
        send(m, d, model(m, d));
    endtask

    // Monitor: pops the scoreboard on each output transfer and checks stall stability
    bit                stalled = 0;
    logic [1:0]        st_m;
    logic [NCH*OW-1:0] st_d;
    exp_t              e;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                checks++;
                if (!out_valid || out_data !== st_d || out_mode !== st_m) begin
                    errors++;
                    $display("FAIL stall_hold got v=%0b m=%0d d=%0h want v=1 m=%0d d=%0h",
                             out_valid, out_mode, out_data, st_m, st_d);
                end
            end
            stalled = out_valid && !out_ready;
            st_m = out_mode;
            st_d = out_data;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got m=%0d d=%0h want none", out_mode, out_data);
                end else begin
                    e = q.pop_front();
                    if (out_mode !== e.m || out_data !== e.d) begin
                        errors++;
                        $display("FAIL output got m=%0d d=%0h want m=%0d d=%0h",
                                 out_mode, out_data, e.m, e.d);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_out_mode", 64'(out_mode), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);

        send(2'd0, lin(0, 0, 0, 0), lout(16, 16, 16, 16));
        in_valid = 1'b0;
        chk("latency_1", 64'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("latency_2", 64'(out_valid), 1);
        send(2'd1, lin(0, 0, 0, 0), lout(0, 0, 0, 0));
        send(2'd0, lin(1024, -1024, 10240, -10240), lout(23, 9, 31, 1));
        send(2'd1, lin(1024, -1024, 10240, -10240), lout(24, -24, 32, -32));
        send(2'd2, lin(-1024, 2560, 10240, 0), lout(0, 80, 127, 0));
        send(2'd3, lin(10240, -10240, 32, 31), lout(127, -128, 1, 0));
        idle(4);

        for (int i = 0; i < 8; i++) begin
            #1;
            chk("stream_in_ready", 64'(in_ready), 1);
            send_rand();
            if (i > 0) chk("stream_out_valid", 64'(out_valid), 1);
        end
        idle(4);

        send_rand();
        idle(1);
        out_ready = 1'b0;
        send_rand();
        chk("stall_in_ready", 64'(in_ready), 0);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready_hold", 64'(in_ready), 0);
        end
        out_ready = 1'b1;
        send_rand();
        send_rand();
        idle(5);

        send_rand();
        send_rand();
        rst = 1'b1;
        in_valid = 1'b0;
        q.delete();
        #1;
        chk("midrst_in_ready", 64'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(out_valid), 0);
        chk("midrst_out_data", 64'(out_data), 0);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("midrst_no_stale", 64'(out_valid), 0);
        end

        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            in_mode   = 2'($urandom_range(0, 3));
            in_data   = {rl(), rl(), rl(), rl()};
            #1;
            if (in_valid && in_ready) q.push_back('{in_mode, model(in_mode, in_data)});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        idle(2);
        chk("drain_empty", 64'(q.size()), 0);
        chk("drain_out_valid", 64'(out_valid), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
